// File: rtl/c4p_sync_rx.sv
// c4p_sync_rx: clocked endpoint for a four-phase bundled-data handshake.
// Define C4P_FIFO_EN for a DEPTH-entry output FIFO; otherwise a single holding register is used.
module c4p_sync_rx #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_i,
  input  logic [W-1:0] data_i,
  output logic         ack_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [7:0]   xfer_cnt
);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   ack_q;
  logic [7:0]             xfer_cnt_q;
  logic [2:0]             settle_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   space_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   valid_s;

  // Request synchronizer chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign pop_s = valid_s && out_ready;

  // Push decode: a capture happens only when leaving IDLE
  always_comb begin
    push_s = 1'b0;
    if ((state_q == IDLE) && req_s && space_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Handshake FSM; RESYNC lets the flushed synchronizer settle so a request
  // held high across reset is seen and waited out rather than captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RESYNC;
      ack_q      <= 1'b0;
      xfer_cnt_q <= 8'd0;
      settle_q   <= 3'd0;
    end else begin
      case (state_q)
        RESYNC: begin
          ack_q <= 1'b0;
          if (settle_q != 3'(SYNC_STAGES)) begin
            settle_q <= settle_q + 3'd1;
          end else if (!req_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (push_s) begin
            state_q    <= ACK;
            ack_q      <= 1'b1;
            xfer_cnt_q <= xfer_cnt_q + 8'd1;
          end
        end
        ACK: begin
          if (!req_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= RESYNC;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef C4P_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (DEPTH < 2)) begin : g_bad_param
    $error("c4p_sync_rx: illegal SYNC_STAGES or DEPTH");
  end

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Circular FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1'b1);
      end
      if (pop_s) begin
        rd_q <= rd_q + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1'b1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign space_s  = (cnt_q < (AW+1)'(DEPTH)) || out_ready;
  assign valid_s  = (cnt_q != {(AW+1){1'b0}});
  assign out_data = mem_q[rd_q];
`else
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (DEPTH < 1)) begin : g_bad_param
    $error("c4p_sync_rx: illegal SYNC_STAGES or DEPTH");
  end

  logic         valid_q;
  logic [W-1:0] data_q;

  // Single holding register; a same-cycle push replaces the popped word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      if (push_s) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
      end else if (pop_s) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign space_s  = !valid_q || out_ready;
  assign valid_s  = valid_q;
  assign out_data = data_q;
`endif

  assign ack_o     = ack_q;
  assign out_valid = valid_s;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_c4p_sync_rx.sv
// Scoreboard bench for c4p_sync_rx: directed handshakes, expected words queued at issue.
module tb_c4p_sync_rx;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DP = 4;

  logic         clk;
  logic         rst_n;
  logic         req_i;
  logic [W-1:0] data_i;
  logic         ack_o;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [7:0]   xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  c4p_sync_rx #(.W(W), .SYNC_STAGES(SS), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .data_i    (data_i),
    .ack_o     (ack_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int n;
    n = 0;
    while ((ack_o !== lvl) && (n < 20)) begin
      tick();
      n++;
    end
    chk(name, 32'(ack_o), 32'(lvl));
  endtask

  task automatic send_word(input logic [W-1:0] d);
    exp_q.push_back(d);
    data_i = d;
    req_i  = 1'b1;
    wait_ack(1'b1, "send_ack_rise");
    req_i = 1'b0;
    wait_ack(1'b0, "send_ack_fall");
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && (n < 20)) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_i     = 1'b0;
    out_ready = 1'b0;
    data_i    = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
  endtask

  // Monitor: every accepted head word is compared with the oldest expected word
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h, expected no word", out_data);
      end else begin
        chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_i = 1'b0; out_ready = 1'b0; data_i = 8'h00;
    repeat (3) tick();
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();

    // single transfer: ack on 3rd edge after the first sampling edge
    data_i = 8'hA5;
    req_i  = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    chk("lat_e1", 32'(ack_o), 32'd0);
    tick();
    chk("lat_e2", 32'(ack_o), 32'd0);
    tick();
    chk("lat_e3_ack", 32'(ack_o), 32'd1);
    chk("lat_e3_valid", 32'(out_valid), 32'd1);
    chk("lat_e3_data", 32'(out_data), 32'hA5);
    req_i = 1'b0;
    tick();
    tick();
    chk("fall_e2", 32'(ack_o), 32'd1);
    tick();
    chk("fall_e3", 32'(ack_o), 32'd0);
    chk("xfer_one", 32'(xfer_cnt), 32'd1);
    drain();

`ifdef C4P_FIFO_EN
    // four words fill the FIFO, the fifth stalls until a pop frees a slot
    for (int k = 1; k <= 4; k++) begin
      send_word(8'(k));
    end
    exp_q.push_back(8'h05);
    data_i = 8'h05;
    req_i  = 1'b1;
    repeat (10) tick();
    chk("fifo_stall_ack", 32'(ack_o), 32'd0);
    chk("fifo_stall_xfer", 32'(xfer_cnt), 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fifo_fullpop_ack", 32'(ack_o), 32'd1);
    chk("fifo_fullpop_head", 32'(out_data), 32'h02);
    chk("fifo_fullpop_xfer", 32'(xfer_cnt), 32'd6);
    req_i = 1'b0;
    wait_ack(1'b0, "fifo_ack_fall");
    drain();
`else
    // holding register: second word stalls until a one-cycle pop
    send_word(8'h11);
    chk("bp_xfer_a", 32'(xfer_cnt), 32'd2);
    exp_q.push_back(8'h22);
    data_i = 8'h22;
    req_i  = 1'b1;
    repeat (10) tick();
    chk("bp_stall_ack", 32'(ack_o), 32'd0);
    chk("bp_stall_xfer", 32'(xfer_cnt), 32'd2);
    chk("bp_stall_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ack", 32'(ack_o), 32'd1);
    chk("bp_release_data", 32'(out_data), 32'h22);
    chk("bp_release_valid", 32'(out_valid), 32'd1);
    chk("bp_release_xfer", 32'(xfer_cnt), 32'd3);
    req_i = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    drain();
`endif

    // reset while in ACK with req held high across the reset
    data_i = 8'h77;
    req_i  = 1'b1;
    wait_ack(1'b1, "mid_pre_ack");
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_ack", 32'(ack_o), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_xfer", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_hold_ack", 32'(ack_o), 32'd0);
    chk("mid_hold_valid", 32'(out_valid), 32'd0);
    chk("mid_hold_xfer", 32'(xfer_cnt), 32'd0);
    req_i = 1'b0;
    repeat (6) tick();
    send_word(8'h3C);
    chk("mid_recap_xfer", 32'(xfer_cnt), 32'd1);
    drain();

    // counter wrap over 256 back-to-back transfers
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_word(8'(i));
      if (i == 254) begin
        chk("wrap_255", 32'(xfer_cnt), 32'd255);
      end
    end
    repeat (4) tick();
    out_ready = 1'b0;
    chk("wrap_zero", 32'(xfer_cnt), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
